// File: rtl/wdt_reset_gen_if.sv
// Wishbone classic slave bus for the reset sequencer's register window.
interface wdt_reset_gen_if;
  logic [31:0] S_ADR_I;
  logic [31:0] S_DAT_I;
  logic        S_WE_I;
  logic        S_STB_I;
  logic        S_CYC_I;
  logic [3:0]  S_SEL_I;
  logic [31:0] S_DAT_O;
  logic        S_ACK_O;
  logic        S_ERR_O;
  logic        S_RTY_O;

  modport master (
    output S_ADR_I, S_DAT_I, S_WE_I, S_STB_I, S_CYC_I, S_SEL_I,
    input  S_DAT_O, S_ACK_O, S_ERR_O, S_RTY_O
  );

  modport slave (
    input  S_ADR_I, S_DAT_I, S_WE_I, S_STB_I, S_CYC_I, S_SEL_I,
    output S_DAT_O, S_ACK_O, S_ERR_O, S_RTY_O
  );
endinterface

// File: rtl/wdt_reset_gen.sv
// Merges watchdog, keyed software and external pin reset requests into one
// stretched system reset, with a sticky cause register and an entry counter.
module wdt_reset_gen #(
  parameter int          HOLD_CYCLES  = 16,
  parameter int          HOLD_WIDTH   = 8,
  parameter int          GUARD_CYCLES = 4,
  parameter logic [7:0]  SW_KEY       = 8'h5A
) (
  input  logic           CLK_I,
  input  logic           RST_I,
  input  logic           RSTREQ_I,
  input  logic           EXT_RST_N_I,
  wdt_reset_gen_if.slave bus,
  output logic           SYS_RST_O
);

  localparam int GUARD_WIDTH = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam int CNT_WIDTH   = (HOLD_WIDTH > GUARD_WIDTH) ? HOLD_WIDTH : GUARD_WIDTH;
  localparam logic [CNT_WIDTH-1:0] HOLD_RELOAD  = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GUARD_RELOAD =
    CNT_WIDTH'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_HOLD,
    S_GUARD,
    S_IDLE
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 sys_rst;
  logic [3:0]           cause;
  logic [7:0]           count;
  logic                 ack;
  logic [31:0]          dat_out;
  logic                 ext_meta;
  logic                 ext_sync;
  logic                 ext_prev;

  logic                 access;
  logic [1:0]           reg_sel;
  logic                 wr_fire;
  logic                 sw_req;
  logic                 ext_req;
  logic                 req;
  logic                 log_req;
  logic [3:0]           req_cause;
  logic [3:0]           cause_clr;
  logic                 count_clr;
  logic [31:0]          read_mux;
  logic                 unused_bus;

  // Register writes take effect at the end of the ack cycle, while the master
  // is still holding address and data stable.
  assign access    = bus.S_STB_I & bus.S_CYC_I;
  assign reg_sel   = bus.S_ADR_I[3:2];
  assign wr_fire   = ack & access & bus.S_WE_I;
  assign sw_req    = wr_fire && (reg_sel == 2'd1) &&
                     (bus.S_DAT_I[15:8] == SW_KEY) && bus.S_DAT_I[0];
  assign ext_req   = ext_prev & ~ext_sync;
  assign req       = RSTREQ_I | sw_req | ext_req;
  assign log_req   = req && (state != S_GUARD);
  assign req_cause = {1'b0, ext_req, sw_req, RSTREQ_I};
  assign cause_clr = (wr_fire && (reg_sel == 2'd0)) ? bus.S_DAT_I[3:0] : 4'b0000;
  assign count_clr = wr_fire && (reg_sel == 2'd2);

  assign unused_bus = ^{bus.S_SEL_I, bus.S_ADR_I[31:4], bus.S_ADR_I[1:0],
                        bus.S_DAT_I[31:16], bus.S_DAT_I[7:4]};

  always_comb begin
    read_mux = 32'h0;
    case (reg_sel)
      2'd0:    read_mux = {28'h0, cause};
      2'd1:    read_mux = {24'h0, SW_KEY};
      2'd2:    read_mux = {24'h0, count};
      default: read_mux = 32'h0;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ack     <= 1'b0;
      dat_out <= 32'h0;
    end else begin
      ack     <= access & ~ack;
      dat_out <= (access & ~ack & ~bus.S_WE_I) ? read_mux : 32'h0;
    end
  end

  // ext_prev trails the synchronised pin by one cycle to detect its falling edge.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ext_meta <= 1'b1;
      ext_sync <= 1'b1;
      ext_prev <= 1'b1;
    end else begin
      ext_meta <= EXT_RST_N_I;
      ext_sync <= ext_meta;
      ext_prev <= ext_sync;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state   <= S_HOLD;
      cnt     <= HOLD_RELOAD;
      sys_rst <= 1'b1;
      cause   <= 4'b1000;
      count   <= 8'h00;
    end else begin
      cause <= (cause & ~cause_clr) | (log_req ? req_cause : 4'b0000);
      if (count_clr)
        count <= 8'h00;
      else if ((state == S_IDLE) && req && (count != 8'hFF))
        count <= count + 8'd1;

      case (state)
        S_HOLD: begin
          if (req) begin
            cnt <= HOLD_RELOAD;
          end else if (cnt == '0) begin
            sys_rst <= 1'b0;
            if (GUARD_CYCLES > 0) begin
              state <= S_GUARD;
              cnt   <= GUARD_RELOAD;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - CNT_WIDTH'(1);
          end
        end
        S_GUARD: begin
          if (cnt == '0)
            state <= S_IDLE;
          else
            cnt <= cnt - CNT_WIDTH'(1);
        end
        S_IDLE: begin
          if (req) begin
            state   <= S_HOLD;
            cnt     <= HOLD_RELOAD;
            sys_rst <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          sys_rst <= 1'b0;
        end
      endcase
    end
  end

  assign SYS_RST_O   = sys_rst;
  assign bus.S_ACK_O = ack;
  assign bus.S_DAT_O = dat_out;
  assign bus.S_ERR_O = 1'b0;
  assign bus.S_RTY_O = 1'b0;

endmodule

// File: doc/wdt_reset_gen.md
# wdt_reset_gen

Reset sequencer directly downstream of the LM32 timer's watchdog reset-request output. It merges the watchdog request, a keyed software reset and a synchronised external reset pin into one stretched system reset `SYS_RST_O`. It also records the cause in a sticky, Wishbone-readable register. Only power-on `RST_I` clears the block; `SYS_RST_O` never resets this block itself.

## Interface
- `HOLD_CYCLES`, 16: cycles `SYS_RST_O` stays high per event (≥1).
- `HOLD_WIDTH`, 8: hold counter width; must satisfy `HOLD_CYCLES < 2**HOLD_WIDTH`.
- `GUARD_CYCLES`, 4: cycles after release during which new requests are ignored (0 = no guard).
- `SW_KEY`, 8'h5A: key required in `S_DAT_I[15:8]` for software reset.
- `CLK_I` in 1: system clock.
- `RST_I` in 1: reset, asynchronous, active-high.
- `RSTREQ_I` in 1: watchdog reset request, one-cycle pulse, `CLK_I` domain.
- `EXT_RST_N_I` in 1: external reset pin, asynchronous, active-low.
- `S_ADR_I` in 32: byte address; bits [3:2] decoded.
- `S_DAT_I` in 32: write data.
- `S_WE_I`, `S_STB_I`, `S_CYC_I` in 1: Wishbone classic controls.
- `S_SEL_I` in 4: ignored; all accesses are 32-bit.
- `S_DAT_O` out 32: read data; 0 when not acking a read.
- `S_ACK_O` out 1: transfer acknowledge.
- `S_ERR_O`, `S_RTY_O` out 1: tied 0.
- `SYS_RST_O` out 1: stretched system reset, active-high.

## Operation
- External pin handling:
  - `EXT_RST_N_I` passes through a 2-flop synchroniser, reset to 1.
  - `ext_req` is a one-cycle pulse on the synchronised falling edge.
- Software request (`sw_req`):
  - Condition: a write to 0x04 with `S_DAT_I[15:8]==SW_KEY` and `S_DAT_I[0]==1`.
  - Asserted in the ack cycle.
  - Wrong key: no effect; the bus still acks.
- `req = RSTREQ_I | sw_req | ext_req`.
- State machine:
  - HOLD: `SYS_RST_O=1`. Counter decrements each cycle. At 0 → GUARD if `GUARD_CYCLES>0`, else IDLE. A `req` in HOLD reloads the counter to `HOLD_CYCLES-1` and its cause bits are ORed in.
  - GUARD: `SYS_RST_O=0`. Counts `GUARD_CYCLES` cycles, then → IDLE. A `req` in GUARD is ignored and not logged.
  - IDLE: `SYS_RST_O=0`. A `req` → HOLD with counter=`HOLD_CYCLES-1`, cause bits set, `rst_count` incremented.
- Registers:
  - 0x00 CAUSE, bits [3:0] = {POR, EXT, SW, WDT}. Sticky. Write-1-to-clear. A set in the same cycle as a clear wins.
  - 0x04 CONTROL: write-only key/trigger. Reads return {24'h0, `SW_KEY`}.
  - 0x08 COUNT, 8 bits: number of IDLE→HOLD entries. Saturates at 255. Any write clears it.
  - 0x0C: reads 0; writes ignored.

## Timing
- Reset values while `RST_I` is high:
  - state=HOLD, counter=`HOLD_CYCLES-1`.
  - `SYS_RST_O=1`, CAUSE=4'b1000, COUNT=0.
  - `S_ACK_O=0`, `S_DAT_O=0`.
- After `RST_I` falls, `SYS_RST_O` stays high exactly `HOLD_CYCLES` more rising edges.
- Request latency:
  - `RSTREQ_I` high at edge n → `SYS_RST_O` high from edge n+1 through edge n+`HOLD_CYCLES`.
  - Released at edge n+`HOLD_CYCLES`+1.
- External pin latency: pin fall → `SYS_RST_O` within 3 edges (2 sync + 1).
- Bus timing:
  - `S_ACK_O` is registered: high one cycle after `STB&CYC` with ack low, for one cycle.
  - Back-to-back transfers therefore take 2 cycles each.
  - `S_DAT_O` is valid in the ack cycle.
- The bus remains functional while `SYS_RST_O` is high.
- `RST_I` mid-HOLD or mid-GUARD aborts the sequence and restarts from the reset values.

## Test plan
- Power-on:
  - Stimulus: release `RST_I`, `HOLD_CYCLES=16`.
  - Response: `SYS_RST_O` high for 16 cycles then low; CAUSE reads 0x8; COUNT reads 0.
- Watchdog pulse:
  - Stimulus: write 0xF to CAUSE, then pulse `RSTREQ_I` at edge n.
  - Response: `SYS_RST_O` high over edges n+1..n+16; CAUSE=0x1; COUNT=1.
- Software key:
  - Stimulus: write 0x0000_3301 to 0x04.
  - Response: no reset. Then write 0x0000_5A01 → reset asserted; CAUSE bit1 set.
- Extension and guard:
  - Stimulus: a second `RSTREQ_I` at HOLD cycle 10, with external pin low.
  - Response: hold extends to 10+16; CAUSE=0x5 (WDT and EXT); COUNT increments by 1 only.
  - Stimulus: a request in GUARD.
  - Response: ignored.
- Saturation and clear collision:
  - Stimulus: 300 watchdog events.
  - Response: COUNT=255.
  - Stimulus: CAUSE write-1-clear in the same cycle as `RSTREQ_I`.
  - Response: WDT bit remains 1.
- Asynchronous reset mid-HOLD:
  - Stimulus: assert `RST_I` at HOLD cycle 5.
  - Response: immediate return to reset values; full 16-cycle hold after release.
